rom_download_ctrl: RTL

Sequences the HPS ROM download into the Galaxian core. It decodes each `ioctl` write into one of three ROM regions (CPU program, tile/sprite graphics, colour PROM) and issues a registered, region-local write strobe. It holds the core in reset during the load and for a fixed settle time afterwards. It reports load completion and errors to the top level. It sits between `hps_io` and the `galaxian` core, replacing the direct `ioctl_*` → `dn_*` wiring and the download term of the core reset.

---
 rtl/rom_download_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rom_download_ctrl.sv
// rtl/rom_download_ctrl.sv - HPS ROM download sequencer and core reset hold for the Galaxian core
// Define ROM_CHECKSUM_EN to add the running modulo-256 byte checksum output.
module rom_download_ctrl #(
  parameter logic [15:0] GFX_BASE    = 16'h4000,
  parameter logic [15:0] PROM_BASE   = 16'h5000,
  parameter int          PROM_SIZE   = 32,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [16:0] byte_count
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int               CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [31:0]      MAP_END     = 32'(PROM_BASE) + 32'(PROM_SIZE);
  localparam logic [16:0]      COUNT_MAX   = 17'h1FFFF;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic             load_entry;
  logic             hold_expire;

  logic [15:0] addr_lo;
  logic [15:0] offset;
  logic        accept;
  logic        out_of_map;
  logic        hit_cpu;
  logic        hit_gfx;
  logic        hit_prom;
  logic        in_map_wr;

  // Region decode; upper address bits beyond the 64 KiB map are always an error.
  always_comb begin
    addr_lo    = ioctl_addr[15:0];
    accept     = ioctl_download & ioctl_wr;
    out_of_map = (|ioctl_addr[24:16]) || ({16'd0, addr_lo} >= MAP_END);
    hit_cpu    = 1'b0;
    hit_gfx    = 1'b0;
    hit_prom   = 1'b0;
    offset     = addr_lo;
    if (accept && !out_of_map) begin
      if (addr_lo < GFX_BASE) begin
        hit_cpu = 1'b1;
        offset  = addr_lo;
      end else if (addr_lo < PROM_BASE) begin
        hit_gfx = 1'b1;
        offset  = addr_lo - GFX_BASE;
      end else begin
        hit_prom = 1'b1;
        offset   = addr_lo - PROM_BASE;
      end
    end
  end

  assign in_map_wr = hit_cpu | hit_gfx | hit_prom;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state <= ST_HOLD;
    end else begin
      state <= state_next;
    end
  end

  // A rising download always wins over hold expiry.
  always_comb begin
    state_next  = state;
    load_entry  = 1'b0;
    hold_expire = 1'b0;
    case (state)
      ST_HOLD: begin
        if (ioctl_download) begin
          state_next = ST_LOAD;
          load_entry = 1'b1;
        end else if (hold_cnt == '0) begin
          state_next  = ST_RUN;
          hold_expire = 1'b1;
        end
      end
      ST_RUN: begin
        if (ioctl_download) begin
          state_next = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_HOLD;
    endcase
  end

  // Counter is parked at the reload value while loading so HOLD always starts full.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      hold_cnt   <= HOLD_RELOAD;
      core_reset <= 1'b1;
    end else begin
      core_reset <= (state_next != ST_RUN);
      if (state == ST_LOAD) begin
        hold_cnt <= HOLD_RELOAD;
      end else if (state == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      cpu_we     <= 1'b0;
      gfx_we     <= 1'b0;
      prom_we    <= 1'b0;
      dn_addr    <= 16'd0;
      dn_data    <= 8'd0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= 17'd0;
    end else begin
      cpu_we  <= hit_cpu;
      gfx_we  <= hit_gfx;
      prom_we <= hit_prom;
      if (in_map_wr) begin
        dn_addr <= offset;
        dn_data <= ioctl_dout;
      end
      // On load entry the clear applies first, then a same-cycle write is counted.
      if (load_entry) begin
        load_done  <= 1'b0;
        load_err   <= accept & out_of_map;
        byte_count <= in_map_wr ? 17'd1 : 17'd0;
      end else begin
        if (hold_expire) begin
          load_done <= (byte_count != 17'd0) && !load_err;
        end
        if (accept && out_of_map) begin
          load_err <= 1'b1;
        end
        if (in_map_wr && byte_count != COUNT_MAX) begin
          byte_count <= byte_count + 17'd1;
        end
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      checksum <= 8'd0;
    end else if (load_entry) begin
      checksum <= in_map_wr ? ioctl_dout : 8'd0;
    end else if (in_map_wr) begin
      checksum <= checksum + ioctl_dout;
    end
  end
`endif

endmodule
